sb_config_loader: RTL

- Upstream feeder for the switchbox configuration shift chain.
- Accepts configuration words from the host/bitstream side over a valid/ready handshake and serializes them LSB-first onto the chain's config_data_in / config_en pins.
- Counts exactly CHAIN_LEN shifted bits and signals completion.
- Captures the bits emerging from the chain tail, so the previous configuration is read back word-by-word during every load.

---
 rtl/sb_config_loader.sv | 103 ++++++++++
 1 files changed

// File: rtl/sb_config_loader.sv
// sb_config_loader: serializes config words LSB-first onto the switchbox chain and captures the old chain contents word-by-word
module sb_config_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 128,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_en,
    output logic              cfg_dout,
    input  logic              cfg_din,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);
    localparam int WI = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] sbuf;
    logic [WORD_W-1:0] rb_cap;
    logic [WORD_W-1:0] rb_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WI-1:0]     widx;
    logic              word_end;
    logic              last_bit;
    logic              shifting;
    logic              accept;

    // Handshake, chain drive and boundary decode; abort masks shifting and acceptance immediately
    always_comb begin
        word_end = widx == WI'(WORD_W - 1);
        last_bit = bit_cnt == CNT_W'(CHAIN_LEN - 1);
        shifting = state == SHIFT && !abort;
        in_ready = !abort && (state == WAIT || (state == SHIFT && word_end && !last_bit));
        accept   = in_ready && in_valid;
        cfg_en   = shifting;
        cfg_dout = state == SHIFT ? sbuf[0] : 1'b0;
        busy     = state != IDLE;
        rb_next  = rb_cap;
        rb_next[widx] = cfg_din;
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? WAIT : IDLE;
            WAIT:    state_next = accept ? SHIFT : WAIT;
            SHIFT:   state_next = last_bit ? DONE : (word_end && !in_valid) ? WAIT : SHIFT;
            default: state_next = IDLE;
        endcase
        if (abort)
            state_next = IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Shift buffer, counters, tail capture and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            sbuf     <= '0;
            rb_cap   <= '0;
            rb_data  <= '0;
            bit_cnt  <= '0;
            widx     <= '0;
            done     <= 1'b0;
            rb_valid <= 1'b0;
        end else begin
            done     <= shifting && last_bit;
            rb_valid <= shifting && (word_end || last_bit);
            if (shifting && (word_end || last_bit))
                rb_data <= rb_next;
            if (state == IDLE && start && !abort)
                bit_cnt <= '0;
            else if (shifting)
                bit_cnt <= bit_cnt + 1'b1;
            if (accept) begin
                sbuf   <= in_data;
                widx   <= '0;
                rb_cap <= '0;
            end else if (shifting) begin
                sbuf   <= sbuf >> 1;
                widx   <= widx + 1'b1;
                rb_cap <= rb_next;
            end
        end
    end
endmodule
